uart_rx_8n1: RTL
================

Name: uart_rx_8n1

Overview:
UART receiver (8N1) matching the board's TX: samples asynchronous rxd, recovers bytes LSB-first and presents them on a valid/ready output. Sits between the board's USB-UART pin and host-command logic on Zybo Z7-20. Includes a 2-FF input synchronizer, mid-bit sampling, false-start rejection, framing-error and overrun flags.

Parameters:
CLK_HZ, 125_000_000, system clock frequency in Hz
BAUD, 115_200, line rate in bit/s; BAUD_DIV = round(CLK_HZ/BAUD) clocks per bit (1085 at defaults)

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
rxd  input  1  asynchronous serial input, idles high
valid  output  1  received byte available in data
ready  input  1  consumer accepts data when valid&ready
data  output  8  received byte, stable while valid=1
frame_err  output  1  one-cycle pulse: stop bit sampled low
overrun  output  1  one-cycle pulse: new byte completed while valid still 1 (new byte dropped)

Behaviour:
- Reset: valid=0, data=8'h00, frame_err=0, overrun=0, state=IDLE, sync FFs=1 (line treated idle).
- Synchronizer: rxd -> s1 -> s2; all logic uses s2 (2-cycle input latency).
- Baud counter width BAUD_W = (BAUD_DIV<=2)?1:$clog2(BAUD_DIV); half-bit = BAUD_DIV/2 (floor).
- IDLE: on s2==0, load cnt=half-1, go START.
- START: count down; at cnt==0 re-sample s2: if 1 -> false start, back to IDLE, no output; if 0 -> cnt=BAUD_DIV-1, bit_idx=0, go DATA.
- DATA: at cnt==0 sample s2 into shreg[7] with right-shift (LSB-first), cnt reload, bit_idx++; after bit_idx==7 sample go STOP.
- STOP: at cnt==0 sample s2: if 1 -> byte good; if 0 -> frame_err pulse 1 cycle, byte discarded, go WAIT_HIGH. Good byte: if valid==0 or (valid&ready) this cycle -> data<=shreg, valid<=1; else overrun pulse, byte discarded, held data untouched. Go IDLE.
- WAIT_HIGH: stay until s2==1 (break / stuck-low line doesn't spawn garbage bytes), then IDLE.
- Output handshake: valid clears on valid&ready unless a new byte loads the same cycle (load wins, valid stays 1). data changes only on load.
- Receiver returns to IDLE at middle of stop bit, so back-to-back frames with zero idle gap are accepted.
- Reset mid-frame: everything returns to reset values next cycle; partial byte dropped.

Optional Feature:
UART_RX_PARITY_EN: when defined, frame is 8E1: one even-parity bit between bit 7 and stop, sampled in a PARITY state; mismatch discards the byte and raises extra output parity_err (1-cycle pulse, reset 0). When undefined: plain 8N1, no parity_err port.

Decomposition:
- Package uart_pkg: state enum (IDLE, START, DATA, PARITY, STOP, WAIT_HIGH), function baud_div(clk_hz, baud) and baud_w(div), shared with uart_tx_8n1.
- Sub-module sync_2ff (width-1 metastability synchronizer, reset value parameter); rest flat.

Test Plan:
- Defaults, send 0x55 then 0xA3 back-to-back at exactly BAUD, ready=1 -> two valid pulses, data 0x55 then 0xA3, no error flags.
- rxd low pulse of BAUD_DIV/4 clocks then high -> no valid, state back in IDLE, next 0x3C received correctly.
- Frame 0x81 with stop bit driven low, then line high -> frame_err pulse exactly once, valid stays 0, next 0x7E received.
- ready=0, send 0x11 then 0x22 -> valid=1 data=0x11 held, overrun pulse on second stop sample; assert ready -> valid drops, data still 0x11.
- Baud skew: transmit 0xF0 at ±3% rate -> correct reception; assert rst mid-byte 4 -> valid=0, data=0x00, no spurious byte afterwards.
- UART_RX_PARITY_EN: 0x07 with correct even parity (1) -> valid data 0x07; with wrong parity -> parity_err pulse, no valid.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter state encoding and baud helpers.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        WAIT_HIGH
    } uart_state_t;

    // Clocks per bit, rounded to nearest.
    function automatic int baud_div(input int clk_hz, input int baud);
        return (clk_hz + baud / 2) / baud;
    endfunction

    // Counter width able to hold div-1.
    function automatic int baud_w(input int div);
        return (div <= 2) ? 1 : $clog2(div);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchronizer for asynchronous inputs.
module sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic s1;

    // Two-stage capture; reset value chosen so the line looks idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= RST_VAL;
            q  <= RST_VAL;
        end else begin
            s1 <= d;
            q  <= s1;
        end
    end

endmodule

// File: rtl/uart_rx_8n1.sv
// UART receiver, 8N1 (8E1 with UART_RX_PARITY_EN defined, adds parity_err).
//
// state     | meaning
// ----------+---------------------------------------------------------
// IDLE      | line high, waiting for start edge
// START     | counting to start-bit centre, rejects glitches
// DATA      | sampling 8 data bits LSB-first at bit centres
// PARITY    | sampling even-parity bit (parity build only)
// STOP      | sampling stop bit, deliver / flag the byte
// WAIT_HIGH | after framing error, wait for line to return high
module uart_rx_8n1
    import uart_pkg::*;
#(
    parameter int CLK_HZ = 125_000_000,
    parameter int BAUD   = 115_200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd,
    output logic       valid,
    input  logic       ready,
    output logic [7:0] data,
    output logic       frame_err,
`ifdef UART_RX_PARITY_EN
    output logic       parity_err,
`endif
    output logic       overrun
);

    localparam int BAUD_DIV = baud_div(CLK_HZ, BAUD);
    localparam int BAUD_W   = baud_w(BAUD_DIV);
    localparam int HALF     = BAUD_DIV / 2;
    localparam logic [BAUD_W-1:0] DIV_M1  = BAUD_W'(BAUD_DIV - 1);
    localparam logic [BAUD_W-1:0] HALF_M1 = BAUD_W'((HALF > 0) ? HALF - 1 : 0);

    logic              s2;
    uart_state_t       state;
    logic [BAUD_W-1:0] cnt;
    logic [2:0]        bit_idx;
    logic [7:0]        shreg;
`ifdef UART_RX_PARITY_EN
    logic              par_bad;
`endif

    sync_2ff #(.RST_VAL(1'b1)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rxd),
        .q   (s2)
    );

    // Receive FSM with down-counting bit timer and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            valid     <= 1'b0;
            data      <= '0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad    <= 1'b0;
            parity_err <= 1'b0;
`endif
        end else begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err <= 1'b0;
`endif
            if (valid && ready)
                valid <= 1'b0;

            case (state)
                IDLE: begin
                    if (!s2) begin
                        cnt   <= HALF_M1;
                        state <= START;
                    end
                end
                START: begin
                    if (cnt != '0)
                        cnt <= cnt - BAUD_W'(1);
                    else if (s2)
                        state <= IDLE;
                    else begin
                        cnt     <= DIV_M1;
                        bit_idx <= '0;
                        state   <= DATA;
                    end
                end
                DATA: begin
                    if (cnt != '0)
                        cnt <= cnt - BAUD_W'(1);
                    else begin
                        shreg   <= {s2, shreg[7:1]};
                        cnt     <= DIV_M1;
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7)
`ifdef UART_RX_PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (cnt != '0)
                        cnt <= cnt - BAUD_W'(1);
                    else begin
                        par_bad <= (^shreg) ^ s2;
                        cnt     <= DIV_M1;
                        state   <= STOP;
                    end
                end
`endif
                STOP: begin
                    if (cnt != '0)
                        cnt <= cnt - BAUD_W'(1);
                    else if (!s2) begin
                        frame_err <= 1'b1;
                        state     <= WAIT_HIGH;
                    end else begin
                        state <= IDLE;
`ifdef UART_RX_PARITY_EN
                        if (par_bad)
                            parity_err <= 1'b1;
                        else
`endif
                        if (!valid || ready) begin
                            data  <= shreg;
                            valid <= 1'b1;
                        end else
                            overrun <= 1'b1;
                    end
                end
                WAIT_HIGH: begin
                    if (s2)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
